// File: rtl/imu_seq_pkg.sv
// imu_seq_pkg: shared states, init table and IMU constants for the read sequencer
package imu_seq_pkg;
  typedef enum logic [3:0] {
    BOOT, INIT_CMD, INIT_DATA, XFER_WAIT, IDLE, RD_CMD, RD_DATA, PUBLISH, BACKOFF
  } state_e;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] d;
  } init_entry_t;
  localparam int INIT_LEN = 4;
  localparam init_entry_t INIT_TBL [INIT_LEN] = '{
    '{8'h6B, 8'h00}, '{8'h1A, 8'h03}, '{8'h1B, 8'h00}, '{8'h1C, 8'h00}
  };
  localparam logic [7:0] IMU_REG_ACCEL_XOUT_H = 8'h3B;
  localparam int IMU_BURST_LEN = 14;
  localparam int BACKOFF_CYCLES = 1000;
endpackage

// File: rtl/imu_sample_tick.sv
// imu_sample_tick: free-running modulo-PERIOD counter, one-cycle tick at PERIOD-1 while enabled
module imu_sample_tick #(
  parameter int PERIOD = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);
  logic [31:0] cnt_q;
  assign tick_o = en_i & (cnt_q == 32'(PERIOD - 1));
  // counter held at zero until enabled, then wraps on every tick
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt_q <= '0;
    else cnt_q <= (!en_i || tick_o) ? '0 : cnt_q + 32'd1;
endmodule

// File: rtl/imu_read_sequencer.sv
// imu_read_sequencer: IMU init + periodic 14-byte burst read over i2c_master; IMU_SEQ_RETRY_EN enables NACK retries
module imu_read_sequencer
  import imu_seq_pkg::*;
#(
`ifdef IMU_SEQ_RETRY_EN
  parameter int RETRY_MAX = 3,
`endif
  parameter logic [6:0] SLAVE_ADDR = 7'h68,
  parameter int SAMPLE_PERIOD = 100000,
  parameter int STARTUP_CYCLES = 10000000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [6:0]         slave_addr_o,
  output logic [7:0]         reg_addr_o,
  output logic [4:0]         byte_len_o,
  output logic [7:0]         wdata_o,
  output logic               rw_mode_o,
  output logic               cmd_valid_o,
  output logic               write_valid_o,
  output logic               read_valid_o,
  input  logic               cmd_ready_i,
  input  logic               write_ready_i,
  input  logic               read_ready_i,
  input  logic [7:0]         data_i,
  input  logic               valid_i,
  input  logic               busy_i,
  input  logic               nack_i,
  output logic signed [15:0] accel_x_o,
  output logic signed [15:0] accel_y_o,
  output logic signed [15:0] accel_z_o,
  output logic signed [15:0] temp_o,
  output logic signed [15:0] gyro_x_o,
  output logic signed [15:0] gyro_y_o,
  output logic signed [15:0] gyro_z_o,
  output logic               sample_valid_o,
  output logic               init_done_o,
  output logic               err_o,
  output logic               overrun_o
);
  state_e      state_q, state_d;
  logic [31:0] tmr_q;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, init_done_q, init_done_d, err_q, err_d, sv_q, rw_q;
  logic [7:0]  reg_q, wd_q;
  logic [4:0]  len_q;
  logic [7:0]  buf_q [IMU_BURST_LEN];
  logic [15:0] word_q [7];
  logic        tick, fall, in_rd, give_up;
`ifdef IMU_SEQ_RETRY_EN
  logic [7:0]  retry_q, retry_d;
  assign give_up = retry_q >= 8'(RETRY_MAX);
`else
  assign give_up = 1'b1;
`endif

  imu_sample_tick #(.PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (init_done_q),
    .tick_o(tick)
  );

  assign fall           = busy_q & ~busy_i;
  assign in_rd          = state_q inside {RD_CMD, RD_DATA, PUBLISH} ||
                          (rw_q && state_q inside {XFER_WAIT, BACKOFF});
  assign slave_addr_o   = SLAVE_ADDR;
  assign reg_addr_o     = reg_q;
  assign byte_len_o     = len_q;
  assign wdata_o        = wd_q;
  assign rw_mode_o      = rw_q;
  assign cmd_valid_o    = state_q inside {INIT_CMD, RD_CMD};
  assign write_valid_o  = state_q == INIT_DATA;
  assign read_valid_o   = state_q == RD_DATA && cnt_q < 4'(IMU_BURST_LEN);
  assign sample_valid_o = sv_q;
  assign init_done_o    = init_done_q;
  assign err_o          = err_q;
  assign overrun_o      = tick & in_rd;
  assign accel_x_o      = word_q[0];
  assign accel_y_o      = word_q[1];
  assign accel_z_o      = word_q[2];
  assign temp_o         = word_q[3];
  assign gyro_x_o       = word_q[4];
  assign gyro_y_o       = word_q[5];
  assign gyro_z_o       = word_q[6];

  // next-state: transaction sequencing, completion on busy falling edge, NACK backoff
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    err_d       = err_q;
`ifdef IMU_SEQ_RETRY_EN
    retry_d     = retry_q;
`endif
    case (state_q)
      BOOT:      if (tmr_q == 32'(STARTUP_CYCLES - 1)) begin
                   state_d = INIT_CMD;
                   idx_d   = '0;
                 end
      INIT_CMD:  if (cmd_ready_i) state_d = INIT_DATA;
      INIT_DATA: if (write_ready_i) state_d = XFER_WAIT;
      XFER_WAIT: if (fall) begin
                   if (nack_i) state_d = BACKOFF;
                   else begin
`ifdef IMU_SEQ_RETRY_EN
                     retry_d = '0;
`endif
                     if (rw_q) state_d = PUBLISH;
                     else if (idx_q == 2'(INIT_LEN - 1)) begin
                       init_done_d = 1'b1;
                       state_d     = IDLE;
                     end else begin
                       idx_d   = idx_q + 2'd1;
                       state_d = INIT_CMD;
                     end
                   end
                 end
      IDLE:      if (tick) state_d = RD_CMD;
      RD_CMD:    begin
                   cnt_d = '0;
                   if (cmd_ready_i) state_d = RD_DATA;
                 end
      RD_DATA:   if (valid_i) begin
                   cnt_d = cnt_q + 4'd1;
                   if (cnt_q == 4'(IMU_BURST_LEN - 1)) state_d = XFER_WAIT;
                 end
      PUBLISH:   state_d = IDLE;
      BACKOFF:   if (tmr_q == 32'(BACKOFF_CYCLES - 1)) begin
                   state_d = give_up ? (rw_q ? IDLE : INIT_CMD) : (rw_q ? RD_CMD : INIT_CMD);
                   err_d   = err_q | give_up;
                   if (give_up && !rw_q) idx_d = '0;
`ifdef IMU_SEQ_RETRY_EN
                   retry_d = give_up ? '0 : retry_q + 8'd1;
`endif
                 end
      default:   state_d = BOOT;
    endcase
    // a NACK can also end the transfer before the data phase finishes
    if (fall && nack_i && state_q inside {INIT_DATA, RD_DATA}) state_d = BACKOFF;
  end

  // state, counters, transaction fields latched on entering a command, buffer and published words
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q     <= BOOT;
      tmr_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      sv_q        <= 1'b0;
      rw_q        <= 1'b0;
      reg_q       <= '0;
      wd_q        <= '0;
      len_q       <= '0;
`ifdef IMU_SEQ_RETRY_EN
      retry_q     <= '0;
`endif
      for (int i = 0; i < IMU_BURST_LEN; i++) buf_q[i] <= '0;
      for (int k = 0; k < 7; k++) word_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= (state_d != state_q) ? '0 : tmr_q + 32'd1;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_i;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      sv_q        <= state_q == PUBLISH;
`ifdef IMU_SEQ_RETRY_EN
      retry_q     <= retry_d;
`endif
      if (state_d == INIT_CMD) begin
        rw_q  <= 1'b0;
        len_q <= 5'd1;
        reg_q <= INIT_TBL[idx_d].r;
        wd_q  <= INIT_TBL[idx_d].d;
      end else if (state_d == RD_CMD) begin
        rw_q  <= 1'b1;
        len_q <= 5'(IMU_BURST_LEN);
        reg_q <= IMU_REG_ACCEL_XOUT_H;
        wd_q  <= '0;
      end
      if (read_valid_o && valid_i) buf_q[cnt_q] <= data_i;
      if (state_q == PUBLISH)
        for (int k = 0; k < 7; k++) word_q[k] <= {buf_q[2*k], buf_q[2*k+1]};
    end
endmodule

// File: tb/tb_imu_read_sequencer.sv
// tb_imu_read_sequencer: table-driven bench with an ACK/NACK i2c_master model for imu_read_sequencer
module tb_imu_read_sequencer;
  localparam int STARTUP = 20;
  localparam int PERIOD  = 2000;

  logic clk = 0, rst_i = 0;
  logic [6:0] slave_addr_o;
  logic [7:0] reg_addr_o, wdata_o, data_i = 0;
  logic [4:0] byte_len_o;
  logic rw_mode_o, cmd_valid_o, write_valid_o, read_valid_o;
  logic cmd_ready_i = 0, write_ready_i = 0, read_ready_i = 0, valid_i = 0, busy_i = 0, nack_i = 0;
  logic signed [15:0] accel_x_o, accel_y_o, accel_z_o, temp_o, gyro_x_o, gyro_y_o, gyro_z_o;
  logic sample_valid_o, init_done_o, err_o, overrun_o;

  imu_read_sequencer #(.SAMPLE_PERIOD(PERIOD), .STARTUP_CYCLES(STARTUP)) dut (
    .clk_i(clk), .rst_i(rst_i), .slave_addr_o(slave_addr_o), .reg_addr_o(reg_addr_o),
    .byte_len_o(byte_len_o), .wdata_o(wdata_o), .rw_mode_o(rw_mode_o),
    .cmd_valid_o(cmd_valid_o), .write_valid_o(write_valid_o), .read_valid_o(read_valid_o),
    .cmd_ready_i(cmd_ready_i), .write_ready_i(write_ready_i), .read_ready_i(read_ready_i),
    .data_i(data_i), .valid_i(valid_i), .busy_i(busy_i), .nack_i(nack_i),
    .accel_x_o(accel_x_o), .accel_y_o(accel_y_o), .accel_z_o(accel_z_o), .temp_o(temp_o),
    .gyro_x_o(gyro_x_o), .gyro_y_o(gyro_y_o), .gyro_z_o(gyro_z_o),
    .sample_valid_o(sample_valid_o), .init_done_o(init_done_o), .err_o(err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [0:13][7:0] b; logic [0:6][15:0] w; } vec_t;
  typedef struct packed { logic [7:0] r; logic [7:0] d; } iv_t;
  vec_t v [2];
  iv_t  iv [4];
  logic [0:13][7:0] tx_b;
  logic [7:0] cap_reg, cap_wd;
  logic [4:0] cap_len;
  logic cap_rw;
  int n_chk = 0, n_pass = 0, ov_cnt = 0, sv_cnt = 0;

  always @(negedge clk) begin
    if (overrun_o) ov_cnt++;
    if (sample_valid_o) sv_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic cur(input int sel);
    return sel == 0 ? cmd_valid_o : sel == 1 ? write_valid_o : err_o;
  endfunction

  task automatic wait_sig(input int sel, input int lim, output int n);
    n = 0;
    while (!cur(sel) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!cur(sel)) begin
      n_chk++;
      $display("FAIL wait_sel%0d: still low after %0d cycles, expected high", sel, lim);
    end
  endtask

  task automatic xact(input bit nack, input int gap, input int lim);
    int n;
    wait_sig(0, lim, n);
    cap_reg = reg_addr_o; cap_rw = rw_mode_o; cap_len = byte_len_o; cap_wd = wdata_o;
    cmd_ready_i = 1; busy_i = 1;
    @(negedge clk);
    cmd_ready_i = 0;
    if (nack) repeat (4) @(negedge clk);
    else if (!cap_rw) begin
      wait_sig(1, 50, n);
      write_ready_i = 1;
      @(negedge clk);
      write_ready_i = 0;
    end else begin
      read_ready_i = 1;
      for (int i = 0; i < 14; i++) begin
        repeat (gap) @(negedge clk);
        chk("read_valid_level", read_valid_o, 1);
        data_i = tx_b[i]; valid_i = 1;
        @(negedge clk);
        valid_i = 0;
      end
      read_ready_i = 0;
    end
    repeat (2) @(negedge clk);
    busy_i = 0; nack_i = nack;
    @(negedge clk);
    nack_i = 0;
  endtask

  task automatic check_pub(input int k);
    logic [0:6][15:0] wv;
    chk("sv_early", sample_valid_o, 0);
    @(negedge clk);
    chk("sv_pulse", sample_valid_o, 1);
    wv = {accel_x_o, accel_y_o, accel_z_o, temp_o, gyro_x_o, gyro_y_o, gyro_z_o};
    for (int j = 0; j < 7; j++) chk($sformatf("word%0d_vec%0d", j, k), 32'(wv[j]), 32'(v[k].w[j]));
    @(negedge clk);
    chk("sv_one_cycle", sample_valid_o, 0);
  endtask

  task automatic run_init();
    int n;
    wait_sig(0, 100, n);
    chk("boot_delay", n, STARTUP);
    for (int i = 0; i < 4; i++) begin
      chk("init_done_early", init_done_o, 0);
      xact(0, 1, 100);
      chk($sformatf("init%0d_rw", i), cap_rw, 0);
      chk($sformatf("init%0d_len", i), cap_len, 1);
      chk($sformatf("init%0d_reg", i), cap_reg, iv[i].r);
      chk($sformatf("init%0d_data", i), cap_wd, iv[i].d);
    end
    chk("init_done", init_done_o, 1);
    chk("err_after_init", err_o, 0);
  endtask

  initial begin
    int n, ov0, sv0;
    iv[0] = '{8'h6B, 8'h00}; iv[1] = '{8'h1A, 8'h03}; iv[2] = '{8'h1B, 8'h00}; iv[3] = '{8'h1C, 8'h00};
    v[0].b = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
    v[0].w = {16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E};
    v[1].b = {8'hFF, 8'h38, 8'h7F, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'hAB, 8'hCD};
    v[1].w = {16'hFF38, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h1234, 16'hABCD};

    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", cmd_valid_o, 0);
    chk("rst_init_done", init_done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_sv", sample_valid_o, 0);
    chk("rst_accel_x", 32'(accel_x_o), 0);
    chk("rst_reg_addr", reg_addr_o, 0);
    chk("slave_addr", slave_addr_o, 7'h68);
    rst_i = 1;
    run_init();

    ov0 = ov_cnt;
    for (int k = 0; k < 2; k++) begin
      tx_b = v[k].b;
      xact(0, 1, 3 * PERIOD);
      chk("rd_rw", cap_rw, 1);
      chk("rd_len", cap_len, 14);
      chk("rd_reg", cap_reg, 8'h3B);
      check_pub(k);
    end
    chk("accel_x_neg200", 32'(accel_x_o), 32'(-200));
    chk("no_overrun_normal", ov_cnt - ov0, 0);

    sv0 = sv_cnt;
    xact(1, 1, 3 * PERIOD);
    chk("nack_on_read", cap_rw, 1);
`ifdef IMU_SEQ_RETRY_EN
    chk("err_first_nack", err_o, 0);
    for (int r = 0; r < 3; r++) begin
      xact(1, 1, 1100);
      chk($sformatf("retry%0d_reg", r), cap_reg, 8'h3B);
      chk($sformatf("retry%0d_err", r), err_o, 0);
    end
`endif
    wait_sig(2, 1100, n);
    chk("err_set", err_o, 1);
    chk("no_publish_on_nack", sv_cnt - sv0, 0);
    tx_b = v[1].b;
    xact(0, 1, 3 * PERIOD);
    check_pub(1);
    chk("err_sticky", err_o, 1);

    ov0 = ov_cnt; sv0 = sv_cnt;
    tx_b = v[0].b;
    xact(0, 300, 3 * PERIOD);
    check_pub(0);
    chk("overrun_pulses", ov_cnt - ov0, 2);
    chk("overrun_one_publish", sv_cnt - sv0, 1);

    wait_sig(0, 3 * PERIOD, n);
    cmd_ready_i = 1; busy_i = 1;
    @(negedge clk);
    cmd_ready_i = 0; read_ready_i = 1;
    for (int i = 0; i < 6; i++) begin
      data_i = v[1].b[i]; valid_i = 1;
      @(negedge clk);
      valid_i = 0;
    end
    rst_i = 0; busy_i = 0; read_ready_i = 0;
    #1;
    chk("mid_rst_accel_x", 32'(accel_x_o), 0);
    chk("mid_rst_gyro_z", 32'(gyro_z_o), 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_init_done", init_done_o, 0);
    chk("mid_rst_read_valid", read_valid_o, 0);
    chk("mid_rst_rw", rw_mode_o, 0);
    chk("mid_rst_len", byte_len_o, 0);
    repeat (3) @(negedge clk);
    rst_i = 1;
    run_init();
    tx_b = v[1].b;
    xact(0, 1, 3 * PERIOD);
    check_pub(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/imu_read_sequencer.md
# imu_read_sequencer

Controls the robbit IMU (MPU-6050-class, 7-bit address 0x68) through the `i2c_master` command/write/read handshakes. It first runs a fixed register-write initialisation list. It then issues a 14-byte burst read from register 0x3B at a fixed sample period and assembles seven signed 16-bit words (accel XYZ, temperature, gyro XYZ). It sits between `i2c_master` and the balance-control datapath, and it is the only requester of that master.

## Interface
- `SLAVE_ADDR`, 7'h68: IMU 7-bit address.
- `SAMPLE_PERIOD`, 100000: cycles between read starts (1 kHz at 100 MHz); minimum 2.
- `STARTUP_CYCLES`, 10000000: delay after reset before the first command.
- `RETRY_MAX`, 3: retries per transaction; used only with `IMU_SEQ_RETRY_EN`.
- `clk_i  in  1`: system clock.
- `rst_i  in  1`: reset, asynchronous, active-low.
- `slave_addr_o  out  7`: driven constant `SLAVE_ADDR`.
- `reg_addr_o  out  8`: register address of the current transaction.
- `byte_len_o  out  5`: write transactions: 1; burst read: 14.
- `wdata_o  out  8`: write data for the current init entry.
- `rw_mode_o  out  1`: 1 = read, 0 = write. Held stable from the command handshake until completion.
- `cmd_valid_o`, `write_valid_o`, `read_valid_o`  out  1 each: requests to the master.
- `cmd_ready_i`, `write_ready_i`, `read_ready_i`  in  1 each: master readies.
- `data_i  in  8`, `valid_i  in  1`: received byte and its strobe.
- `busy_i  in  1`, `nack_i  in  1`: master status.
- `accel_x_o`, `accel_y_o`, `accel_z_o`, `temp_o`, `gyro_x_o`, `gyro_y_o`, `gyro_z_o`  out  16 each, signed: last published sample.
- `sample_valid_o  out  1`: one-cycle pulse on publish.
- `init_done_o  out  1`: level; set when the init list completes.
- `err_o  out  1`: sticky; set on an unrecovered NACK.
- `overrun_o  out  1`: one-cycle pulse when a tick arrives while a read is still in progress.

## Operation
- Reset values: all outputs 0, state `BOOT`.
- State flow: `BOOT` → `INIT_CMD` → `INIT_DATA` → `XFER_WAIT` → (next entry, or `IDLE`) → `RD_CMD` → `RD_DATA` → `XFER_WAIT` → `PUBLISH` → `IDLE`. Any NACK goes to `BACKOFF`.
- `BOOT`: count `STARTUP_CYCLES`, then go to `INIT_CMD` with entry index 0.
- Init list: 4 entries of {reg, data}: {0x6B,0x00}, {0x1A,0x03}, {0x1B,0x00}, {0x1C,0x00}.
- `INIT_CMD`: assert `cmd_valid_o` with `rw_mode_o`=0 and `byte_len_o`=1. On `cmd_valid_o & cmd_ready_i`, drop the request and go to `INIT_DATA`.
- `INIT_DATA`: hold `write_valid_o` until `write_valid_o & write_ready_i`, then go to `XFER_WAIT`.
- `XFER_WAIT`: completion is a 1→0 edge of `busy_i`, detected against a registered copy. `nack_i` is sampled in the same cycle.
  - Success on entries 0–2: index+1, go to `INIT_CMD`.
  - Success on entry 3: set `init_done_o`, start the period timer, go to `IDLE`.
  - Success on a read: go to `PUBLISH`.
  - NACK: go to `BACKOFF`.
- `IDLE`: wait for the period tick, then go to `RD_CMD`.
- `RD_CMD`: `reg_addr_o`=0x3B, `rw_mode_o`=1, `byte_len_o`=14. Assert `cmd_valid_o` until accepted.
- `RD_DATA`: `read_valid_o` = (byte count < 14). Hold it as a level, not a pulse, because `read_ready_i` stays high for the whole read phase.
  - Each `valid_i` stores `data_i` at index = count, then count+1.
  - At count 14, go to `XFER_WAIT`.
- Word assembly: word k = {byte[2k], byte[2k+1]}, big-endian, k = 0..6, in output order accel X/Y/Z, temp, gyro X/Y/Z.
- `PUBLISH`: load all seven outputs in the same cycle and pulse `sample_valid_o`. Outputs are not updated on a failed or partial read.
- `BACKOFF`: wait 1000 cycles, then apply the Configuration rule.
- Period tick while a read is between `RD_CMD` and `PUBLISH`: pulse `overrun_o`. The tick is dropped, not queued.
- Reset mid-transfer (the master shares `rst_i`): return to `BOOT`, clear `init_done_o` and `err_o`, and rerun the full init list.

## Timing
- Period timer: free-running modulo `SAMPLE_PERIOD` from the `init_done_o` set cycle. Tick is a one-cycle pulse when count = `SAMPLE_PERIOD`-1.
- Read start: `cmd_valid_o` rises 1 cycle after the tick when in `IDLE`.
- Publish latency: `sample_valid_o` rises exactly 2 cycles after the `busy_i` falling edge of a successful read (edge register + `PUBLISH`).
- Outputs hold their value until the next publish.
- `rw_mode_o` and `reg_addr_o` may change only in `IDLE`/`BOOT` or on entering `INIT_CMD`/`RD_CMD`.

## Configuration
- `IMU_SEQ_RETRY_EN` defined:
  - After `BACKOFF`, the failed transaction is reissued, up to `RETRY_MAX` times. The retry counter resets on any success.
  - When retries are exhausted: set `err_o`. Init restarts from entry 0; a read abandons the sample and returns to `IDLE`.
- `IMU_SEQ_RETRY_EN` undefined:
  - The first NACK sets `err_o`. Same restart/abandon rule.
  - `RETRY_MAX` is unused and no retry counter is built.

## Structure
- Package `imu_seq_pkg`: state enum, init-table type and the 4-entry constant, `IMU_REG_ACCEL_XOUT_H` = 8'h3B, `IMU_BURST_LEN` = 14, `BACKOFF_CYCLES` = 1000.
- Sub-module `imu_sample_tick`: period counter with enable. Outputs `tick`.
- Byte buffer: 14×8 register array inside the top module.

## Test plan
- Init: after `STARTUP_CYCLES`, a slave model ACKs everything → 4 write transactions in order (0x6B/0x00, 0x1A/0x03, 0x1B/0x00, 0x1C/0x00); `init_done_o`=1; `err_o`=0.
- Burst: slave returns bytes 0x01..0x0E → accel_x=0x0102, temp=0x0708, gyro_z=0x0D0E; one-cycle `sample_valid_o` 2 cycles after `busy_i` falls.
- Sign: bytes 0xFF,0x38 for accel_x → `accel_x_o` = -200.
- NACK on the read address byte, macro on, `RETRY_MAX`=3 → 3 reissues; 4th NACK sets `err_o`, no publish, next tick reads normally. Macro off → `err_o` on the first NACK.
- Overrun: `SAMPLE_PERIOD`=2000, shorter than a burst → `overrun_o` pulses once per missed tick; publishes stay consistent.
- Reset asserted mid-`RD_DATA` at byte 6 → all outputs 0 immediately; after release, full init replays before any read.
